// File: rtl/bg_comp_pkg.sv
// Shared constants for the background layer compositor: register map,
// field widths, CTRL bit positions and the bus write-mask decode.
package bg_comp_pkg;

  localparam int RGB_W = 6;
  localparam int VEL_W = 4;

  localparam logic [5:0] ADDR_CTRL        = 6'h00;
  localparam logic [5:0] ADDR_LAYER_EN    = 6'h04;
  localparam logic [5:0] ADDR_STATUS      = 6'h08;
  localparam logic [5:0] ADDR_FRAME_CNT   = 6'h0C;
  localparam logic [5:0] ADDR_BACKDROP    = 6'h10;
  localparam logic [5:0] ADDR_AUTO_VEL    = 6'h14;
  localparam logic [5:0] ADDR_SCROLL_BASE = 6'h20;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Bytes touched by a write: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = none.
  function automatic logic [31:0] write_mask(input logic [1:0] wr_n);
    case (wr_n)
      2'b00:   write_mask = 32'h0000_00FF;
      2'b01:   write_mask = 32'h0000_FFFF;
      2'b10:   write_mask = 32'hFFFF_FFFF;
      default: write_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/bg_layer_mixer.sv
// Fixed-priority layer select with backdrop fallback and blanking, registered
// together with the syncs so uo_out stays aligned with its pixel.
module bg_layer_mixer
  import bg_comp_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        vid_visible,
  input  logic                        vid_hsync,
  input  logic                        vid_vsync,
  input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_opaque,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [RGB_W-1:0]            backdrop,
  output logic [7:0]                  uo_out
);

  logic [RGB_W-1:0] pix;
  logic             found;
  logic [7:0]       uo_d, uo_q;

  // Lowest enabled opaque layer wins; nothing opaque shows the backdrop.
  always_comb begin
    pix   = backdrop;
    found = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!found && layer_en[i] && layer_opaque[i]) begin
        pix   = layer_rgb[i*RGB_W +: RGB_W];
        found = 1'b1;
      end
    end
    if (!(vid_visible && run)) pix = '0;
    uo_d = {vid_vsync, vid_hsync, pix};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) uo_q <= '0;
    else        uo_q <= uo_d;
  end

  assign uo_out = uo_q;

endmodule

// File: rtl/bg_layer_compositor.sv
// Background compositor: register file, shadowed per-layer scroll with
// per-frame auto-scroll, frame counter / vblank interrupt, and the mixer.
module bg_layer_compositor
  import bg_comp_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int SCROLL_W   = 11,
  parameter bit VSYNC_POL  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [5:0]                     address,
  input  logic [31:0]                    data_in,
  input  logic [1:0]                     data_write_n,
  input  logic [1:0]                     data_read_n,
  output logic [31:0]                    data_out,
  output logic                           data_ready,
  output logic                           user_interrupt,
  input  logic                           vid_hsync,
  input  logic                           vid_vsync,
  input  logic                           vid_visible,
  output logic                           vga_en,
  input  logic [RGB_W*NUM_LAYERS-1:0]    layer_rgb,
  input  logic [NUM_LAYERS-1:0]          layer_opaque,
  output logic [NUM_LAYERS-1:0]          layer_en,
  output logic [SCROLL_W*NUM_LAYERS-1:0] layer_scroll,
  output logic [7:0]                     uo_out
);

  logic [1:0]            ctrl_q, ctrl_d;
  logic [NUM_LAYERS-1:0] len_q, len_d;
  logic                  vblank_pend_q, vblank_pend_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [RGB_W-1:0]      backdrop_q, backdrop_d;
  logic [31:0]           auto_vel_q, auto_vel_d;
  logic [SCROLL_W-1:0]   active_q [NUM_LAYERS];
  logic [SCROLL_W-1:0]   active_d [NUM_LAYERS];
  logic [SCROLL_W-1:0]   pend_off_q [NUM_LAYERS];
  logic [SCROLL_W-1:0]   pend_off_d [NUM_LAYERS];
  logic [SCROLL_W-1:0]   dx_ext [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] pend_v_q, pend_v_d;
  logic                  vsync_q, vga_en_q, irq_q;
  logic [NUM_LAYERS-1:0] layer_en_q;

  logic        wr, fb, scroll_hit;
  logic [2:0]  scroll_idx;
  logic [31:0] wmask;
  logic        unused_rd;

  assign unused_rd  = ^data_read_n;
  assign wr         = (data_write_n != 2'b11);
  assign wmask      = write_mask(data_write_n);
  assign scroll_hit = ((address & 6'b10_0011) == ADDR_SCROLL_BASE);
  assign scroll_idx = address[4:2];
  // Frame boundary: first cycle vsync reaches its active level while running.
  assign fb = ctrl_q[CTRL_RUN] && (vid_vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    assign dx_ext[g] = {{(SCROLL_W-VEL_W){auto_vel_q[g*VEL_W+VEL_W-1]}},
                        auto_vel_q[g*VEL_W +: VEL_W]};
    assign layer_scroll[g*SCROLL_W +: SCROLL_W] = active_q[g];
  end

  always_comb begin
    ctrl_d        = ctrl_q;
    len_d         = len_q;
    vblank_pend_d = vblank_pend_q;
    frame_cnt_d   = frame_cnt_q;
    backdrop_d    = backdrop_q;
    auto_vel_d    = auto_vel_q;
    pend_v_d      = pend_v_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      active_d[i]   = active_q[i];
      pend_off_d[i] = pend_off_q[i];
    end

    // fb consumes pending offsets as they stood before this cycle's write.
    if (fb) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (pend_v_q[i]) begin
          active_d[i] = pend_off_q[i];
          pend_v_d[i] = 1'b0;
        end else begin
          active_d[i] = active_q[i] + dx_ext[i];
        end
      end
    end

    if (wr) begin
      case (address)
        ADDR_CTRL:     ctrl_d     = data_in[1:0];
        ADDR_LAYER_EN: len_d      = data_in[NUM_LAYERS-1:0];
        ADDR_STATUS:   if (data_in[0]) vblank_pend_d = 1'b0;
        ADDR_BACKDROP: backdrop_d = data_in[RGB_W-1:0];
        ADDR_AUTO_VEL: auto_vel_d = (auto_vel_q & ~wmask) | (data_in & wmask);
        default: ;
      endcase
      if (scroll_hit) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (scroll_idx == 3'(i)) begin
            pend_off_d[i] = (active_q[i] & ~wmask[SCROLL_W-1:0]) |
                            (data_in[SCROLL_W-1:0] & wmask[SCROLL_W-1:0]);
            pend_v_d[i]   = 1'b1;
          end
        end
      end
    end

    if (fb) vblank_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q        <= '0;
      len_q         <= '0;
      vblank_pend_q <= 1'b0;
      frame_cnt_q   <= '0;
      backdrop_q    <= '0;
      auto_vel_q    <= '0;
      pend_v_q      <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        active_q[i]   <= '0;
        pend_off_q[i] <= '0;
      end
      vsync_q    <= 1'b0;
      vga_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      layer_en_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      len_q         <= len_d;
      vblank_pend_q <= vblank_pend_d;
      frame_cnt_q   <= frame_cnt_d;
      backdrop_q    <= backdrop_d;
      auto_vel_q    <= auto_vel_d;
      pend_v_q      <= pend_v_d;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        active_q[i]   <= active_d[i];
        pend_off_q[i] <= pend_off_d[i];
      end
      vsync_q    <= vid_vsync;
      vga_en_q   <= ctrl_q[CTRL_RUN];
      irq_q      <= vblank_pend_q & ctrl_q[CTRL_IRQ_EN];
      layer_en_q <= len_q & {NUM_LAYERS{ctrl_q[CTRL_RUN]}};
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:      data_out[1:0]            = ctrl_q;
      ADDR_LAYER_EN:  data_out[NUM_LAYERS-1:0] = len_q;
      ADDR_STATUS:    data_out[0]              = vblank_pend_q;
      ADDR_FRAME_CNT: data_out[15:0]           = frame_cnt_q;
      ADDR_BACKDROP:  data_out[RGB_W-1:0]      = backdrop_q;
      ADDR_AUTO_VEL:  data_out                 = auto_vel_q;
      default: ;
    endcase
    if (scroll_hit) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (scroll_idx == 3'(i)) data_out[SCROLL_W-1:0] = active_q[i];
      end
    end
  end

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_q;
  assign vga_en         = vga_en_q;
  assign layer_en       = layer_en_q;

  bg_layer_mixer #(.NUM_LAYERS(NUM_LAYERS)) u_mixer (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (ctrl_q[CTRL_RUN]),
    .vid_visible  (vid_visible),
    .vid_hsync    (vid_hsync),
    .vid_vsync    (vid_vsync),
    .layer_rgb    (layer_rgb),
    .layer_opaque (layer_opaque),
    .layer_en     (layer_en_q),
    .backdrop     (backdrop_q),
    .uo_out       (uo_out)
  );

endmodule

// File: doc/bg_layer_compositor.md
Name: bg_layer_compositor

Overview:
Parametrised successor to the single-select background peripheral.
- Composites NUM_LAYERS background generators by fixed priority with per-layer transparency and a register-programmable backdrop colour. Simultaneous enables are a normal mode, not an error.
- Owns per-layer horizontal scroll offsets. Software updates are shadowed, and an optional per-frame auto-scroll velocity is applied at each frame boundary.
- Raises a vblank interrupt, and drives the 8-bit VGA PMOD word {vsync, hsync, B, G, R}.
- Sits between the TinyQV bus / video timing controller and the layer generators.

Parameters:
- NUM_LAYERS, 4, number of layer inputs; legal range 1..8.
- SCROLL_W, 11, width of each scroll offset in bits.
- VSYNC_POL, 1, active level of vid_vsync (1 = active high).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- address  in  6  register address.
- data_in  in  32  write data.
- data_write_n  in  2  11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit.
- data_read_n  in  2  read strobe; unused functionally.
- data_out  out  32  read data, combinational from address.
- data_ready  out  1  tied 1.
- user_interrupt  out  1  level interrupt.
- vid_hsync  in  1  from the video controller.
- vid_vsync  in  1  from the video controller.
- vid_visible  in  1  active video.
- vga_en  out  1  enable to the video controller.
- layer_rgb  in  6*NUM_LAYERS  {B,G,R} 2 bits each; layer i at [6i+5:6i].
- layer_opaque  in  NUM_LAYERS  1 = layer pixel is opaque.
- layer_en  out  NUM_LAYERS  registered enables to the generators.
- layer_scroll  out  SCROLL_W*NUM_LAYERS  active offsets to the generators.
- uo_out  out  8  {vsync, hsync, B[1:0], G[1:0], R[1:0]}.

Behaviour:
- Reset (rst_n low at a clk edge) clears every register, pending flag, counter and pipeline stage.
  - All outputs are 0 except data_ready = 1.
- Reset mid-frame gives uo_out = 0 on the next cycle.
- Writes: any data_write_n != 11 is a write.
  - 8-bit writes update register bits [7:0] only; 16-bit writes update [15:0]; 32-bit writes update all bits.
  - Reads of unmapped addresses return 0.
- Register map:
  - 0x00 CTRL: [0] run, [1] vblank_irq_en.
  - 0x04 LAYER_EN: [NUM_LAYERS-1:0].
  - 0x08 STATUS: [0] vblank_pend, write-1-to-clear.
  - 0x0C FRAME_CNT: [15:0], read-only.
  - 0x10 BACKDROP: [5:0] {B,G,R}.
  - 0x14 AUTO_VEL: 4-bit signed dx per layer, layer i at [4i+3:4i]. Layers 0..7 fit in 32 bits.
  - 0x20+4i SCROLL_i: [SCROLL_W-1:0]; reads return the active offset.
- vga_en = CTRL.run, registered one cycle.
- layer_en = LAYER_EN & {NUM_LAYERS{run}}, registered one cycle.
- Frame boundary fb: one-cycle pulse when vid_vsync makes its transition to the active level VSYNC_POL, detected against a registered copy. fb is suppressed when run = 0.
- Scroll shadow:
  - A write to SCROLL_i loads pend_off_i and sets pend_v_i.
  - On fb, each layer does one of the following:
    - if pend_v_i: active_i <= pend_off_i, and pend_v_i is cleared;
    - otherwise: active_i <= active_i + sign-extended dx_i, modulo 2^SCROLL_W (wraps both directions).
  - A SCROLL_i write in the same cycle as fb is not consumed by that fb; it is applied at the next fb.
- On fb: FRAME_CNT increments, wrapping 0xFFFF -> 0, and vblank_pend is set.
- vblank_pend: set and W1C in the same cycle resolves as set.
- user_interrupt = vblank_pend & vblank_irq_en, registered.
- Mixer, one-cycle pipeline:
  - Winner = lowest index i with layer_en[i] & layer_opaque[i].
  - Output = layer_rgb of the winner; if there is no winner, BACKDROP.
  - Output is forced to 0 when vid_visible = 0 or run = 0.
  - hsync and vsync are delayed one register stage so uo_out stays aligned with its pixel.
- Total latency from vid_* / layer_* inputs to uo_out is exactly 1 clk.

Decomposition:
- Package bg_comp_pkg holds:
  - register address constants (ADDR_CTRL, ADDR_LAYER_EN, ADDR_STATUS, ADDR_FRAME_CNT, ADDR_BACKDROP, ADDR_AUTO_VEL, ADDR_SCROLL_BASE);
  - RGB_W = 6;
  - VEL_W = 4;
  - CTRL bit indices.
- One sub-module, bg_layer_mixer, parametrised by NUM_LAYERS. It contains the priority select, the backdrop fallback, blanking and the 1-cycle output register including the sync delay.
- Register file, scroll shadowing and frame logic stay in bg_layer_compositor.

Test Plan:
- Reset / enable: reset, then write CTRL = 0x01 and LAYER_EN = 0xF.
  - Next cycle: vga_en = 1 and layer_en = 0xF.
  - Before the writes: uo_out = 0x00 and user_interrupt = 0.
- Priority: layer_opaque = 4'b1010, layer1 rgb = 0x15, layer3 rgb = 0x2A, BACKDROP = 0x3F, vid_visible = 1.
  - uo_out[5:0] = 0x15 one cycle later.
  - With layer_opaque = 0: uo_out[5:0] = 0x3F.
  - With vid_visible = 0: uo_out[5:0] = 0.
- Shadowed scroll: write SCROLL_0 = 0x123 mid-frame.
  - Reads show the old value and layer_scroll[0] is unchanged until the vsync edge.
  - Active value = 0x123 from the cycle after fb.
  - Repeat the write coincident with fb: it is applied one frame later.
- Auto-scroll wrap: SCROLL_1 = 0x7FE with AUTO_VEL layer1 = +3.
  - After fb: 0x001.
  - With dx = -2 from 0x001: 0x7FF.
- Interrupt: CTRL = 0x03, one frame.
  - vblank_pend = 1, user_interrupt = 1, FRAME_CNT += 1.
  - W1C to STATUS clears it.
  - W1C coincident with fb leaves it set.
- Byte write: 32-bit AUTO_VEL = 0xFFFFFFFF, then 8-bit write 0x00.
  - Readback = 0xFFFFFF00.
